// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, fetch handshake, skid buffer and IF/ID register.
// Optional performance counters are enabled by defining IF_STAGE_PERF_CNT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] redirect_cnt
`endif
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HELD  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   tgt_q, tgt_d;
  logic [XLEN-1:0]   skid_q, skid_d;
  logic [XLEN-1:0]   ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0]   ifid_pc4_q, ifid_pc4_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic              req_q, req_d;

  logic              redirect_c;
  logic [XLEN-1:0]   redir_tgt_c;
  logic [XLEN-1:0]   pc4_c;
  logic              ack_c;
  logic              load_c;

  // Redirect decode: jump has priority over branch; ack only counts while requesting
  always_comb begin
    redirect_c  = |pcsrc;
    redir_tgt_c = pcsrc[1] ? jump_target : branch_target;
    pc4_c       = pc_q + XLEN'(4);
    ack_c       = imem_ack & req_q;
  end

  // Next-state and datapath control
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    skid_d       = skid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    load_c       = 1'b0;

    case (state_q)
      S_REQ: begin
        if (redirect_c) begin
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
          if (ack_c) begin
            pc_d = redir_tgt_c;
          end else begin
            tgt_d   = redir_tgt_c;
            state_d = S_DRAIN;
          end
        end else if (ack_c) begin
          if (stall) begin
            skid_d  = imem_rdata;
            state_d = S_HELD;
          end else begin
            ifid_instr_d = imem_rdata;
            ifid_pc4_d   = pc4_c;
            ifid_valid_d = 1'b1;
            load_c       = 1'b1;
            pc_d         = pc4_c;
          end
        end
      end
      S_HELD: begin
        if (redirect_c) begin
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
          skid_d       = '0;
          pc_d         = redir_tgt_c;
          state_d      = S_REQ;
        end else if (!stall) begin
          ifid_instr_d = skid_q;
          ifid_pc4_d   = pc4_c;
          ifid_valid_d = 1'b1;
          load_c       = 1'b1;
          pc_d         = pc4_c;
          state_d      = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect_c) begin
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
          tgt_d        = redir_tgt_c;
        end
        if (ack_c) begin
          pc_d    = redirect_c ? redir_tgt_c : tgt_q;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    req_d = (state_d != S_HELD);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      tgt_q        <= '0;
      skid_q       <= '0;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      skid_q       <= skid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      req_q        <= req_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_valid = ifid_valid_q;

`ifdef IF_STAGE_PERF_CNT_EN
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [XLEN-1:0] redirect_cnt_q, redirect_cnt_d;

  // Counter increments: valid IF/ID loads and redirect cycles, wrapping naturally
  always_comb begin
    fetch_cnt_d    = fetch_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (load_c)     fetch_cnt_d    = fetch_cnt_q + XLEN'(1);
    if (redirect_c) redirect_cnt_d = redirect_cnt_q + XLEN'(1);
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign fetch_cnt    = fetch_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus pushes expected IF/ID loads, a monitor pops and compares.
module tb_if_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  pcsrc;
  logic [31:0] branch_target, jump_target;
  logic        stall;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] ifid_instr, ifid_pc4;
  logic        ifid_valid;

  logic        mem_auto, ack_man;
  logic [31:0] rdata_man;

  logic        req2;
  logic [31:0] addr2, instr2, pc4_2;
  logic        valid2;

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] fetch_cnt, redirect_cnt, fetch_cnt2, redirect_cnt2;
`endif

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  // Memory responder: zero-wait in auto mode, otherwise driven by the stimulus
  assign imem_ack   = mem_auto ? imem_req : ack_man;
  assign imem_rdata = mem_auto ? word(imem_addr) : rdata_man;

  if_stage #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .pcsrc(pcsrc),
    .branch_target(branch_target), .jump_target(jump_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid)
`ifdef IF_STAGE_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .redirect_cnt(redirect_cnt)
`endif
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .pcsrc(2'b00),
    .branch_target(32'h0), .jump_target(32'h0), .stall(1'b0),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(req2), .imem_rdata(word(addr2)),
    .ifid_instr(instr2), .ifid_pc4(pc4_2), .ifid_valid(valid2)
`ifdef IF_STAGE_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt2), .redirect_cnt(redirect_cnt2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] addr);
    exp_t e;
    e.instr = word(addr);
    e.pc4   = addr + 32'd4;
    sb_q.push_back(e);
  endtask

  // Monitor: a new IF/ID load is any valid content differing from the previous cycle
  initial begin
    logic        pv;
    logic [31:0] pi, pp;
    exp_t        e;
    pv = 1'b0; pi = '0; pp = '0;
    forever begin
      @(negedge clk);
      if (rst_n && ifid_valid && (!pv || ifid_instr !== pi || ifid_pc4 !== pp)) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_load: got instr %h pc4 %h, expected no load at %0t",
                   ifid_instr, ifid_pc4, $time);
        end else begin
          e = sb_q.pop_front();
          chk("sb_instr", ifid_instr, e.instr);
          chk("sb_pc4", ifid_pc4, e.pc4);
        end
      end
      pv = ifid_valid; pi = ifid_instr; pp = ifid_pc4;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; pcsrc = 2'b00; branch_target = '0; jump_target = '0; stall = 1'b0;
    mem_auto = 1'b1; ack_man = 1'b0; rdata_man = '0;
    tick(); tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(ifid_valid), 32'd0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_pc4", ifid_pc4, 32'h0);

    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    rst_n = 1'b1;
    tick();                                   // P1
    chk("p1_req", 32'(imem_req), 32'd1);
    chk("p1_addr", imem_addr, 32'h0);
    chk("p1_valid", 32'(ifid_valid), 32'd0);
    tick();                                   // P2
    chk("wrap_pc4", pc4_2, 32'h0);
    chk("wrap_valid", 32'(valid2), 32'd1);
    chk("wrap_addr", addr2, 32'h0);
    tick(); tick(); tick();                   // P5: pc = 0x10
    stall = 1'b1;
    push(32'h10);
    tick();                                   // P6: word 0x10 buffered
    chk("hold_pc4", ifid_pc4, 32'h10);
    chk("hold_instr", ifid_instr, word(32'hC));
    tick();                                   // P7
    chk("held_req", 32'(imem_req), 32'd0);
    chk("held_pc4", ifid_pc4, 32'h10);
    chk("held_instr", ifid_instr, word(32'hC));
    tick();                                   // P8
    chk("held2_pc4", ifid_pc4, 32'h10);
    chk("held2_valid", 32'(ifid_valid), 32'd1);
    stall = 1'b0;
    tick();                                   // P9: buffered word loaded
    pcsrc = 2'b01; branch_target = 32'h100;
    tick();                                   // P10: redirect with ack
    chk("br_valid", 32'(ifid_valid), 32'd0);
    chk("br_instr", ifid_instr, 32'h0);
    chk("br_pc4", ifid_pc4, 32'h14);
    chk("br_addr", imem_addr, 32'h100);
    mem_auto = 1'b0; pcsrc = 2'b11; jump_target = 32'h200;
    tick();                                   // P11: redirect without ack -> drain
    chk("drain_addr", imem_addr, 32'h100);
    chk("drain_req", 32'(imem_req), 32'd1);
    pcsrc = 2'b00;
    tick();                                   // P12
    ack_man = 1'b1; rdata_man = 32'hDEAD_BEEF;
    tick();                                   // P13: stale word dropped
    chk("jmp_addr", imem_addr, 32'h200);
    chk("jmp_req", 32'(imem_req), 32'd1);
    chk("jmp_valid", 32'(ifid_valid), 32'd0);
    ack_man = 1'b0; pcsrc = 2'b01; branch_target = 32'h300;
    tick();                                   // P14
    pcsrc = 2'b10; jump_target = 32'h400;
    tick();                                   // P15
    pcsrc = 2'b00; ack_man = 1'b1;
    tick();                                   // P16
    chk("last_wins_addr", imem_addr, 32'h400);
    push(32'h400); rdata_man = word(32'h400);
    tick();                                   // P17: load 0x400
    stall = 1'b1; rdata_man = word(32'h404);
    tick();                                   // P18: buffered under stall
    ack_man = 1'b0; pcsrc = 2'b01; branch_target = 32'h500;
    tick();                                   // P19: redirect in HELD
    chk("hred_valid", 32'(ifid_valid), 32'd0);
    chk("hred_pc4", ifid_pc4, 32'h404);
    chk("hred_addr", imem_addr, 32'h500);
    chk("hred_req", 32'(imem_req), 32'd1);
    pcsrc = 2'b00; stall = 1'b0; mem_auto = 1'b1;
    push(32'h500);
    tick();                                   // P20: load 0x500
`ifdef IF_STAGE_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, 32'd7);
    chk("redirect_cnt", redirect_cnt, 32'd5);
`endif
    mem_auto = 1'b0;
    tick();                                   // P21: request pending on 0x504
    rst_n = 1'b0; ack_man = 1'b1; rdata_man = 32'hBAD0_BAD0;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_valid", 32'(ifid_valid), 32'd0);
    chk("arst_pc4", ifid_pc4, 32'h0);
    chk("arst_instr", ifid_instr, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
`ifdef IF_STAGE_PERF_CNT_EN
    chk("arst_fetch_cnt", fetch_cnt, 32'd0);
    chk("arst_redirect_cnt", redirect_cnt, 32'd0);
`endif
    tick();                                   // P22: stray ack under reset
    rst_n = 1'b1;
    tick();                                   // P23: stray ack before request
    chk("stray_valid", 32'(ifid_valid), 32'd0);
    chk("stray_addr", imem_addr, 32'h0);
    ack_man = 1'b0;
    tick();                                   // P24
    chk("stray2_valid", 32'(ifid_valid), 32'd0);
    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
